// File: rtl/alu_seq_if.sv
// Operand/result bundle for alu_seq: valid/ready request side plus registered results.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic [4:0]       alu_opcode;
  logic [WIDTH-1:0] op_in_1;
  logic [WIDTH-1:0] op_in_2;
  logic             carry_in;
  logic             aux_carry_in;
  logic             bit_in;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] op_out_1;
  logic [WIDTH-1:0] op_out_2;
  logic             carry_out;
  logic             aux_carry_out;
  logic             overflow_out;

  modport master (
    output alu_opcode, op_in_1, op_in_2, carry_in, aux_carry_in, bit_in, in_valid,
    input  in_ready, out_valid, op_out_1, op_out_2, carry_out, aux_carry_out, overflow_out
  );

  modport slave (
    input  alu_opcode, op_in_1, op_in_2, carry_in, aux_carry_in, bit_in, in_valid,
    output in_ready, out_valid, op_out_1, op_out_2, carry_out, aux_carry_out, overflow_out
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential 8051-style ALU: single-cycle arithmetic/logic/BCD ops, iterative
// shift-add MUL and restoring DIV, registered results with a one-cycle out_valid pulse.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input logic       clock,
  input logic       reset,
  alu_seq_if.slave  bus
);
  localparam int unsigned SW = $clog2(WIDTH);

  typedef enum logic [4:0] {
    OP_INC  = 5'h00, OP_DEC  = 5'h01, OP_ADD  = 5'h02, OP_ADDC = 5'h03,
    OP_SUBB = 5'h04, OP_MUL  = 5'h05, OP_DIV  = 5'h06, OP_RR   = 5'h07,
    OP_RRC  = 5'h08, OP_RL   = 5'h09, OP_RLC  = 5'h0A, OP_CPL  = 5'h0B,
    OP_DA   = 5'h0C, OP_SWAP = 5'h0D, OP_ORL  = 5'h0E, OP_XRL  = 5'h0F,
    OP_ANL  = 5'h10
  } op_t;

  typedef enum logic {IDLE, ITER} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    step_q;
  logic             is_div_q;
  logic [WIDTH-1:0] m_q, hi_q, lo_q, hi_d, lo_d;
  logic [WIDTH-1:0] op1_q, op2_q;
  logic             cy_q, ac_q, ov_q, valid_q;

  logic [WIDTH-1:0] a, b;
  op_t              op;
  logic             accept, start_iter, last_step;

  logic [WIDTH-1:0] s_op1, s_op2;
  logic             s_cy, s_ac, s_ov;
  logic             c_add;
  logic [WIDTH:0]   add_full, sub_full, mul_sum, div_trial;
  logic [WIDTH-1:0] add_low;
  logic [4:0]       add_nib, sub_nib;
  logic [8:0]       da_1, da_2;

  assign a         = bus.op_in_1;
  assign b         = bus.op_in_2;
  assign op        = op_t'(bus.alu_opcode);
  assign accept    = bus.in_valid && (state_q == IDLE);
  assign last_step = (step_q == SW'(WIDTH - 1));

  assign bus.in_ready      = (state_q == IDLE) && !reset;
  assign bus.out_valid     = valid_q;
  assign bus.op_out_1      = op1_q;
  assign bus.op_out_2      = op2_q;
  assign bus.carry_out     = cy_q;
  assign bus.aux_carry_out = ac_q;
  assign bus.overflow_out  = ov_q;

  always_comb begin
    c_add    = (op == OP_ADDC) && bus.carry_in;
    add_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_add};
    add_low  = {1'b0, a[WIDTH-2:0]} + {1'b0, b[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, c_add};
    add_nib  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, c_add};
    sub_full = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bus.carry_in};
    sub_nib  = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'b0, bus.carry_in};
    // Decimal adjust: second correction also fires on the first step's carry out of bit 7
    da_1 = {1'b0, a[7:0]};
    if (a[3:0] > 4'd9 || bus.aux_carry_in) da_1 = da_1 + 9'h006;
    da_2 = {1'b0, da_1[7:0]};
    if (da_1[7:4] > 4'd9 || bus.carry_in || da_1[8]) da_2 = da_2 + 9'h060;
  end

  always_comb begin
    s_op1      = op1_q;
    s_op2      = op2_q;
    s_cy       = cy_q;
    s_ac       = ac_q;
    s_ov       = ov_q;
    start_iter = 1'b0;
    case (op)
      OP_INC:  s_op1 = a + WIDTH'(1);
      OP_DEC:  s_op1 = a - WIDTH'(1);
      OP_ADD, OP_ADDC: begin
        s_op1 = add_full[WIDTH-1:0];
        s_cy  = add_full[WIDTH];
        s_ac  = add_nib[4];
        s_ov  = add_low[WIDTH-1] ^ add_full[WIDTH];
      end
      OP_SUBB: begin
        s_op1 = sub_full[WIDTH-1:0];
        s_cy  = sub_full[WIDTH];
        s_ac  = sub_nib[4];
        s_ov  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
      end
      OP_MUL:  start_iter = 1'b1;
      OP_DIV: begin
        if (b == '0) begin
          s_op1 = '1;
          s_op2 = a;
          s_ov  = 1'b1;
          s_cy  = 1'b0;
        end else begin
          start_iter = 1'b1;
        end
      end
      OP_RR:   s_op1 = {a[0], a[WIDTH-1:1]};
      OP_RRC: begin
        s_op1 = {bus.carry_in, a[WIDTH-1:1]};
        s_cy  = a[0];
      end
      OP_RL:   s_op1 = {a[WIDTH-2:0], a[WIDTH-1]};
      OP_RLC: begin
        s_op1 = {a[WIDTH-2:0], bus.carry_in};
        s_cy  = a[WIDTH-1];
      end
      OP_CPL:  s_op1 = ~a;
      OP_DA: begin
        s_op1      = a;
        s_op1[7:0] = da_2[7:0];
        s_cy       = bus.carry_in | da_1[8] | da_2[8];
      end
      OP_SWAP: s_op1 = {a[WIDTH/2-1:0], a[WIDTH-1:WIDTH/2]};
      OP_ORL: begin
        s_op1 = a | b;
        s_cy  = bus.carry_in | bus.bit_in;
      end
      OP_XRL:  s_op1 = a ^ b;
      OP_ANL: begin
        s_op1 = a & b;
        s_cy  = bus.carry_in & bus.bit_in;
      end
      default: ;
    endcase
  end

  // One iteration: MUL shifts {hi,lo} right after a conditional add; DIV shifts left with restoring subtract
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    div_trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, m_q};
    if (is_div_q) begin
      if (!div_trial[WIDTH]) begin
        hi_d = div_trial[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_d = mul_sum[WIDTH:1];
      lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && start_iter) state_d = ITER;
      ITER: if (last_step) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step_q   <= '0;
      is_div_q <= 1'b0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      cy_q     <= 1'b0;
      ac_q     <= 1'b0;
      ov_q     <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (state_q == IDLE) begin
        if (accept) begin
          step_q <= '0;
          if (start_iter) begin
            is_div_q <= (op == OP_DIV);
            hi_q     <= '0;
            m_q      <= (op == OP_DIV) ? b : a;
            lo_q     <= (op == OP_DIV) ? a : b;
          end else begin
            valid_q <= 1'b1;
            op1_q   <= s_op1;
            op2_q   <= s_op2;
            cy_q    <= s_cy;
            ac_q    <= s_ac;
            ov_q    <= s_ov;
          end
        end
      end else begin
        step_q <= step_q + SW'(1);
        hi_q   <= hi_d;
        lo_q   <= lo_d;
        if (last_step) begin
          valid_q <= 1'b1;
          op1_q   <= lo_d;
          op2_q   <= hi_d;
          cy_q    <= 1'b0;
          ov_q    <= !is_div_q && (hi_d != '0);
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Randomised self-checking bench for alu_seq against an arithmetic reference model,
// plus hand-computed directed cases and a 16-bit MUL instance.
module tb_alu_seq;
  localparam int W = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  alu_seq_if #(.WIDTH(8))  bus8 ();
  alu_seq_if #(.WIDTH(16)) bus16 ();

  alu_seq #(.WIDTH(8))  dut   (.clock(clock), .reset(reset), .bus(bus8));
  alu_seq #(.WIDTH(16)) dut16 (.clock(clock), .reset(reset), .bus(bus16));

  typedef struct {
    logic [7:0] o1;
    logic [7:0] o2;
    logic       cy;
    logic       ac;
    logic       ov;
    logic       iter;
    int         due;
  } res_t;

  res_t q[$];
  res_t mstate;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   busy_lo = 0;
  int   busy_hi = 0;
  logic exp_v;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h time=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    mstate = '{o1: 8'h00, o2: 8'h00, cy: 1'b0, ac: 1'b0, ov: 1'b0, iter: 1'b0, due: 0};
  endtask

  function automatic res_t model(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic ci, input logic aci, input logic bi, input res_t p);
    res_t r;
    int s, c, v;
    logic c1, c2;
    r = p;
    r.iter = 1'b0;
    case (op)
      5'h00: r.o1 = a + 8'd1;
      5'h01: r.o1 = a - 8'd1;
      5'h02, 5'h03: begin
        c = (op == 5'h03) ? int'(ci) : 0;
        s = int'(a) + int'(b) + c;
        r.o1 = s[7:0];
        r.cy = s > 255;
        r.ac = (int'(a[3:0]) + int'(b[3:0]) + c) > 15;
        s = int'($signed(a)) + int'($signed(b)) + c;
        r.ov = (s > 127) || (s < -128);
      end
      5'h04: begin
        s = int'(a) - int'(b) - int'(ci);
        r.o1 = s[7:0];
        r.cy = s < 0;
        r.ac = int'(a[3:0]) < (int'(b[3:0]) + int'(ci));
        s = int'($signed(a)) - int'($signed(b)) - int'(ci);
        r.ov = (s > 127) || (s < -128);
      end
      5'h05: begin
        s = int'(a) * int'(b);
        r.o1 = s[7:0];
        r.o2 = s[15:8];
        r.cy = 1'b0;
        r.ov = s > 255;
        r.iter = 1'b1;
      end
      5'h06: begin
        r.cy = 1'b0;
        if (b == 8'h00) begin
          r.o1 = 8'hFF;
          r.o2 = a;
          r.ov = 1'b1;
        end else begin
          r.o1 = a / b;
          r.o2 = a % b;
          r.ov = 1'b0;
          r.iter = 1'b1;
        end
      end
      5'h07: r.o1 = (a >> 1) | (a << 7);
      5'h08: begin r.o1 = (a >> 1) | {ci, 7'b0}; r.cy = a[0]; end
      5'h09: r.o1 = (a << 1) | (a >> 7);
      5'h0A: begin r.o1 = (a << 1) | {7'b0, ci}; r.cy = a[7]; end
      5'h0B: r.o1 = ~a;
      5'h0C: begin
        v = int'(a);
        if ((v % 16) > 9 || aci) v = v + 6;
        c1 = v > 255;
        v = v % 256;
        if ((v / 16) > 9 || ci || c1) v = v + 96;
        c2 = v > 255;
        r.o1 = v[7:0];
        r.cy = ci | c1 | c2;
      end
      5'h0D: r.o1 = (a << 4) | (a >> 4);
      5'h0E: begin r.o1 = a | b; r.cy = ci | bi; end
      5'h0F: r.o1 = a ^ b;
      5'h10: begin r.o1 = a & b; r.cy = ci & bi; end
      default: ;
    endcase
    return r;
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      exp_v = (q.size() > 0) && (q[0].due == cyc);
      chk("in_ready", bus8.in_ready, !((cyc >= busy_lo) && (cyc < busy_hi)));
      chk("out_valid", bus8.out_valid, exp_v);
      if (exp_v) begin
        chk("op_out_1", bus8.op_out_1, q[0].o1);
        chk("op_out_2", bus8.op_out_2, q[0].o2);
        chk("carry_out", bus8.carry_out, q[0].cy);
        chk("aux_carry_out", bus8.aux_carry_out, q[0].ac);
        chk("overflow_out", bus8.overflow_out, q[0].ov);
        void'(q.pop_front());
      end else if (q.size() > 0 && q[0].due < cyc) begin
        void'(q.pop_front());
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic aci, input logic bi);
    int n;
    res_t r;
    n = 0;
    @(negedge clock);
    while (!bus8.in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!bus8.in_ready) begin
      chk("ready_timeout", bus8.in_ready, 1'b1);
      return;
    end
    bus8.alu_opcode   = op;
    bus8.op_in_1      = a;
    bus8.op_in_2      = b;
    bus8.carry_in     = ci;
    bus8.aux_carry_in = aci;
    bus8.bit_in       = bi;
    bus8.in_valid     = 1'b1;
    @(posedge clock);
    #1;
    bus8.in_valid   = 1'b0;
    bus8.alu_opcode = 5'($urandom);
    bus8.op_in_1    = 8'($urandom);
    bus8.op_in_2    = 8'($urandom);
    bus8.carry_in   = 1'($urandom);
    r = model(op, a, b, ci, aci, bi, mstate);
    r.due = cyc + (r.iter ? W : 0);
    if (r.iter) begin
      busy_lo = cyc;
      busy_hi = cyc + W;
    end
    mstate = r;
    q.push_back(r);
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 60; i++) begin
      if (q.size() == 0) break;
      @(negedge clock);
      #1;
    end
    chk("drain_pending", q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] op;
    logic [7:0] ra, rb;
    int k, low;
    logic got;

    bus8.alu_opcode = '0; bus8.op_in_1 = '0; bus8.op_in_2 = '0;
    bus8.carry_in = 1'b0; bus8.aux_carry_in = 1'b0; bus8.bit_in = 1'b0; bus8.in_valid = 1'b0;
    bus16.alu_opcode = '0; bus16.op_in_1 = '0; bus16.op_in_2 = '0;
    bus16.carry_in = 1'b0; bus16.aux_carry_in = 1'b0; bus16.bit_in = 1'b0; bus16.in_valid = 1'b0;
    clear_model();

    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("rst_op_out_1", bus8.op_out_1, 8'h00);
    chk("rst_op_out_2", bus8.op_out_2, 8'h00);
    chk("rst_flags", {bus8.carry_out, bus8.aux_carry_out, bus8.overflow_out}, 3'b000);
    chk("rst_out_valid", bus8.out_valid, 1'b0);
    chk("rst_in_ready", bus8.in_ready, 1'b1);

    issue(5'h02, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0); drain();
    chk("add_o1", bus8.op_out_1, 8'h80);
    chk("add_cy_ac_ov", {bus8.carry_out, bus8.aux_carry_out, bus8.overflow_out}, 3'b011);
    issue(5'h04, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0); drain();
    chk("subb_o1", bus8.op_out_1, 8'hFF);
    chk("subb_cy_ac_ov", {bus8.carry_out, bus8.aux_carry_out, bus8.overflow_out}, 3'b110);
    issue(5'h03, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0); drain();
    chk("addc_o1", bus8.op_out_1, 8'h10);
    chk("addc_ac", bus8.aux_carry_out, 1'b1);
    issue(5'h05, 8'h80, 8'h02, 1'b1, 1'b0, 1'b0); drain();
    chk("mul_o2_o1", {bus8.op_out_2, bus8.op_out_1}, 16'h0100);
    chk("mul_cy_ov", {bus8.carry_out, bus8.overflow_out}, 2'b01);
    issue(5'h06, 8'hFB, 8'h12, 1'b0, 1'b0, 1'b0); drain();
    chk("div_q_r", {bus8.op_out_1, bus8.op_out_2}, 16'h0D11);
    chk("div_ov", bus8.overflow_out, 1'b0);
    issue(5'h06, 8'h55, 8'h00, 1'b0, 1'b0, 1'b0); drain();
    chk("div0_q_r", {bus8.op_out_1, bus8.op_out_2}, 16'hFF55);
    chk("div0_ov", bus8.overflow_out, 1'b1);
    issue(5'h0C, 8'h9A, 8'h00, 1'b0, 1'b0, 1'b0); drain();
    chk("da_o1_cy", {bus8.op_out_1, bus8.carry_out}, 9'h001);
    issue(5'h0D, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0); drain();
    chk("swap_o1", bus8.op_out_1, 8'h5A);
    issue(5'h0A, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0); drain();
    chk("rlc_o1_cy", {bus8.op_out_1, bus8.carry_out}, 9'h001);

    issue(5'h05, 8'hC3, 8'h5A, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    q.delete();
    busy_lo = 0;
    busy_hi = 0;
    clear_model();
    #1;
    chk("midrst_outs", {bus8.op_out_1, bus8.op_out_2}, 16'h0000);
    chk("midrst_flags_valid", {bus8.carry_out, bus8.aux_carry_out, bus8.overflow_out, bus8.out_valid}, 4'h0);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("midrst_in_ready", bus8.in_ready, 1'b1);
    repeat (W + 2) @(posedge clock);

    issue(5'h00, 8'hFE, 8'h00, 1'b0, 1'b0, 1'b0);
    issue(5'h00, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
    issue(5'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    drain();
    chk("inc_last", bus8.op_out_1, 8'h01);

    for (int i = 0; i < 300; i++) begin
      if ($urandom % 3 == 0) repeat ($urandom_range(1, 3)) @(posedge clock);
      op = ($urandom % 8 == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
      ra = 8'($urandom);
      rb = ($urandom % 8 == 0) ? 8'h00 : 8'($urandom);
      issue(op, ra, rb, 1'($urandom), 1'($urandom), 1'($urandom));
    end
    drain();

    @(negedge clock);
    bus16.alu_opcode = 5'h05;
    bus16.op_in_1    = 16'hFFFF;
    bus16.op_in_2    = 16'hFFFF;
    bus16.in_valid   = 1'b1;
    @(posedge clock);
    #1 bus16.in_valid = 1'b0;
    k = 0;
    low = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      k++;
      if (bus16.out_valid) got = 1'b1;
      else if (!bus16.in_ready) low++;
    end
    chk("mul16_valid_seen", got, 1'b1);
    chk("mul16_edges_to_valid", k - 1, 16);
    chk("mul16_ready_low", low, 16);
    chk("mul16_hi_lo", {bus16.op_out_2, bus16.op_out_1}, 32'hFFFE0001);
    chk("mul16_cy_ov", {bus16.carry_out, bus16.overflow_out}, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised sequential successor to the core 8051 ALU. Handles single-cycle arithmetic, logic, rotate and BCD ops, plus iterative multi-cycle MUL/DIV.
- Operands enter through a valid/ready handshake; results are registered.
- Sits between the operand-fetch logic and the accumulator/B/PSW writeback. PSW flag semantics are corrected to the true 8051 definitions.

Parameters:
- WIDTH, 8, operand/result width; must be a multiple of 4 and at least 8.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- alu_opcode  in  5  operation select, sampled on accept
- op_in_1  in  WIDTH  first operand (A)
- op_in_2  in  WIDTH  second operand (B / divisor / multiplier)
- carry_in  in  1  PSW.CY
- aux_carry_in  in  1  PSW.AC
- bit_in  in  1  addressed bit operand for ORL/ANL C,bit
- in_valid  in  1  request; accepted when in_valid & in_ready
- in_ready  out  1  high in IDLE only
- out_valid  out  1  one-cycle pulse, results updated
- op_out_1  out  WIDTH  primary result (A / product low / quotient)
- op_out_2  out  WIDTH  product high / remainder
- carry_out  out  1  CY result
- aux_carry_out  out  1  AC result
- overflow_out  out  1  OV result

Behaviour:
- Reset value: every output is 0. in_ready is 1 once reset deasserts. FSM goes to IDLE. A reset during ITER abandons the operation; no out_valid is produced.
- Opcodes: 00 INC, 01 DEC, 02 ADD, 03 ADDC, 04 SUBB, 05 MUL, 06 DIV, 07 RR, 08 RRC, 09 RL, 0A RLC, 0B CPL, 0C DA, 0D SWAP, 0E ORL, 0F XRL, 10 ANL.
  - 11..1F are NOP: out_valid still pulses, and all outputs hold.
- Outputs not listed for an op hold their previous registered value. op_out_2 changes only on MUL/DIV.
- Operands and opcode are captured on the accept edge. Inputs are don't-care afterwards.
- FSM states:
  - IDLE (in_ready=1).
    - Accepting a single-cycle op: the result is registered on the accept edge N, out_valid=1 in the cycle after N, and the FSM stays in IDLE. Back-to-back accepts are allowed, one per cycle.
    - Accepting MUL, or DIV with nonzero divisor: go to ITER with step=0.
  - ITER (in_ready=0).
    - Performs one shift-add (MUL) or restoring-subtract (DIV) step per clock.
    - On step WIDTH-1, at edge N+WIDTH, results are written, out_valid pulses in the following cycle, and the FSM returns to IDLE.
    - in_valid is ignored while in ITER.
- Arithmetic:
  - INC/DEC: wrap modulo 2^WIDTH; flags hold.
  - ADD/ADDC: sum = A+B(+CY).
    - CY = carry out of the MSB.
    - AC = carry out of bit 3.
    - OV = carry into MSB XOR carry out of MSB.
  - SUBB: A-B-CY.
    - CY = borrow out of the MSB.
    - AC = borrow from bit 3.
    - OV = signed overflow, i.e. operands of differing sign and result sign differing from A.
  - MUL: {op_out_2,op_out_1} = A*B, unsigned. CY=0. OV = (op_out_2 != 0).
  - DIV, B != 0: op_out_1 = A/B, op_out_2 = A%B. CY=0, OV=0.
  - DIV, B == 0: completes as a single-cycle op. op_out_1 = all ones, op_out_2 = A, OV=1, CY=0.
  - RR/RL: rotate the full WIDTH.
  - RRC/RLC: rotate through CY; CY gets the bit shifted out.
  - CPL: bitwise NOT.
  - SWAP: exchange the upper and lower WIDTH/2 halves.
  - DA: acts on bits[7:0] only; bits above 7 pass through.
    - Step 1: if bits[3:0] > 9 or AC, add 0x06.
    - Step 2: if the resulting bits[7:4] > 9 or CY, or step 1 carried out of bit 7, add 0x60.
    - CY is set if either step carries out of bit 7, otherwise it holds the CY input. AC and OV hold.
  - ORL: A|B, and CY = carry_in|bit_in.
  - ANL: A&B, and CY = carry_in&bit_in.
  - XRL: A^B; flags hold.

Test Plan:
- ADD, A=0x7F, B=0x01 -> op_out_1=0x80, OV=1, AC=1, CY=0, with out_valid in the cycle after accept.
- SUBB, A=0x00, B=0x01, CY=0 -> op_out_1=0xFF, CY=1, AC=1, OV=0. Then ADDC, A=0x0F, B=0x00, CY=1 -> 0x10, AC=1.
- MUL with WIDTH=8, A=0x80, B=0x02 -> op_out_2=0x01, op_out_1=0x00, OV=1, CY=0.
  - in_ready stays low for exactly 8 cycles; out_valid appears 8 edges after accept.
  - With WIDTH=16, 0xFFFF*0xFFFF -> 0xFFFE and 0x0001 after 16 edges.
- DIV, A=0xFB, B=0x12 -> op_out_1=0x0D, op_out_2=0x11, OV=0. DIV, A=0x55, B=0x00 -> out_valid next cycle, OV=1, op_out_1=0xFF, op_out_2=0x55.
- DA, A=0x9A, AC=0, CY=0 -> op_out_1=0x00, CY=1. SWAP 0xA5 -> 0x5A. RLC 0x80 with CY=0 -> 0x00, CY=1.
- Reset asserted at step 3 of a MUL -> outputs 0 and in_ready=1 immediately, with no out_valid. Then three back-to-back INC accepts from 0xFE -> results 0xFF, 0x00, 0x01 on consecutive cycles.
